// File: rtl/l2_fwd_stall_ctrl_pkg.sv
// Shared types and constants for the L2 forward-stall controller.
package l2_fwd_stall_ctrl_pkg;

    // Outstanding-request table index width and default counter width.
    localparam int unsigned REQS_BITS           = 3;
    localparam int unsigned STALL_CNT_BITS_DFLT = 16;

    // Payload field types shared with the rest of the L2.
    typedef logic [27:0] line_addr_t;
    typedef logic [2:0]  mix_msg_t;
    typedef logic [3:0]  cache_id_t;
    typedef logic [3:0]  word_mask_t;

    // Stall FSM state encodings.
    localparam logic [1:0] FWD_IDLE    = 2'd0;
    localparam logic [1:0] FWD_STALLED = 2'd1;
    localparam logic [1:0] FWD_ENDED   = 2'd2;

endpackage

// File: rtl/l2_fwd_stall_ctrl.sv
// Parks a forward that conflicts with an outstanding request, holds the
// decoder off while the request is pending, then offers the forward for
// replay once the conflicting entry retires.
module l2_fwd_stall_ctrl
    import l2_fwd_stall_ctrl_pkg::*;
#(
    parameter int unsigned STALL_CNT_BITS = STALL_CNT_BITS_DFLT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      set_fwd_stall,
    input  logic [REQS_BITS-1:0]      set_fwd_stall_entry,
    input  line_addr_t                fwd_in_addr_in,
    input  mix_msg_t                  fwd_in_coh_msg_in,
    input  cache_id_t                 fwd_in_req_id_in,
    input  word_mask_t                fwd_in_word_mask_in,
    input  logic                      clr_entry_valid,
    input  logic [REQS_BITS-1:0]      clr_entry_idx,
    input  logic                      set_fwd_in_from_stalled,
    output logic                      fwd_stall,
    output logic                      fwd_stall_ended,
    output line_addr_t                fwd_in_stalled_addr,
    output mix_msg_t                  fwd_in_stalled_coh_msg,
    output cache_id_t                 fwd_in_stalled_req_id,
    output word_mask_t                fwd_in_stalled_word_mask,
    output logic [STALL_CNT_BITS-1:0] stall_cycles,
    output logic                      stall_protocol_err
);

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [REQS_BITS-1:0]      r_entry;
    line_addr_t                r_addr;
    mix_msg_t                  r_coh_msg;
    cache_id_t                 r_req_id;
    word_mask_t                r_word_mask;
    logic [STALL_CNT_BITS-1:0] r_cnt;
    logic                      r_err;
    logic                      r_fwd_stall;
    logic                      r_fwd_stall_ended;

    logic w_accept;
    logic w_new_hit;
    logic w_old_hit;
    logic w_illegal;

    // A capture is legal from IDLE, or from ENDED when the replay is consumed
    // in the same cycle (the replay re-conflicts).
    assign w_accept  = set_fwd_stall &&
                       ((r_state == FWD_IDLE) ||
                        ((r_state == FWD_ENDED) && set_fwd_in_from_stalled));
    assign w_new_hit = clr_entry_valid && (clr_entry_idx == set_fwd_stall_entry);
    assign w_old_hit = clr_entry_valid && (clr_entry_idx == r_entry);
    assign w_illegal = (set_fwd_stall && !w_accept) ||
                       (set_fwd_in_from_stalled && (r_state != FWD_ENDED));

    // Next-state selection; an accepted capture overrides the per-state rules.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = w_new_hit ? FWD_ENDED : FWD_STALLED;
        end else begin
            case (r_state)
                FWD_IDLE:    w_state_nxt = FWD_IDLE;
                FWD_STALLED: if (w_old_hit) w_state_nxt = FWD_ENDED;
                FWD_ENDED:   if (set_fwd_in_from_stalled) w_state_nxt = FWD_IDLE;
                default:     w_state_nxt = FWD_IDLE;
            endcase
        end
    end

    // State, registered status outputs and sticky protocol error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= FWD_IDLE;
            r_fwd_stall       <= 1'b0;
            r_fwd_stall_ended <= 1'b0;
            r_err             <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_fwd_stall       <= (w_state_nxt != FWD_IDLE);
            r_fwd_stall_ended <= (w_state_nxt == FWD_ENDED);
            if (w_illegal) r_err <= 1'b1;
        end
    end

    // Parked payload and entry index load only on an accepted capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry     <= '0;
            r_addr      <= '0;
            r_coh_msg   <= '0;
            r_req_id    <= '0;
            r_word_mask <= '0;
        end else if (w_accept) begin
            r_entry     <= set_fwd_stall_entry;
            r_addr      <= fwd_in_addr_in;
            r_coh_msg   <= fwd_in_coh_msg_in;
            r_req_id    <= fwd_in_req_id_in;
            r_word_mask <= fwd_in_word_mask_in;
        end
    end

    // Saturating count of cycles spent in STALLED; restarts on capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == FWD_STALLED) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign fwd_stall                = r_fwd_stall;
    assign fwd_stall_ended          = r_fwd_stall_ended;
    assign fwd_in_stalled_addr      = r_addr;
    assign fwd_in_stalled_coh_msg   = r_coh_msg;
    assign fwd_in_stalled_req_id    = r_req_id;
    assign fwd_in_stalled_word_mask = r_word_mask;
    assign stall_cycles             = r_cnt;
    assign stall_protocol_err       = r_err;

endmodule

// File: doc/l2_fwd_stall_ctrl.md
L2_FWD_STALL_CTRL -- requirements
Module: l2_fwd_stall_ctrl

Interface
REQ-001 Parameter: STALL_CNT_BITS, default 16, width of the saturating stall-cycle counter.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high (ports clk and rst).
REQ-003 clk  in  1  block clock, all state updates on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 set_fwd_stall  in  1  forward in lookup conflicts with an outstanding request; capture it.
REQ-006 set_fwd_stall_entry  in  `REQS_BITS  index of the conflicting outstanding-request entry.
REQ-007 fwd_in_addr_in  in  line_addr_t  address of the forward to park.
REQ-008 fwd_in_coh_msg_in  in  mix_msg_t  coherence message of the forward to park.
REQ-009 fwd_in_req_id_in  in  cache_id_t  requester id of the forward to park.
REQ-010 fwd_in_word_mask_in  in  word_mask_t  word mask of the forward to park.
REQ-011 clr_entry_valid  in  1  an outstanding-request entry retires this cycle.
REQ-012 clr_entry_idx  in  `REQS_BITS  index of the retiring entry.
REQ-013 set_fwd_in_from_stalled  in  1  input decoder consumes the parked forward this cycle.
REQ-014 fwd_stall  out  1  a forward is parked; decoder must not accept new forwards.
REQ-015 fwd_stall_ended  out  1  parked forward is replayable.
REQ-016 fwd_in_stalled_addr / _coh_msg / _req_id / _word_mask  out  types as REQ-007..010  parked payload.
REQ-017 stall_cycles  out  STALL_CNT_BITS  cycles spent in STALLED for the current or last stall.
REQ-018 stall_protocol_err  out  1  sticky flag for an illegal set_fwd_stall.

Function
REQ-019 The FSM SHALL have states IDLE, STALLED and ENDED. Outputs: fwd_stall=1 in STALLED and ENDED; fwd_stall_ended=1 only in ENDED; both are registered.
REQ-020 IDLE + set_fwd_stall: capture payload and entry index, move to STALLED, clear stall_cycles to 0.
REQ-021 Same cycle as REQ-020, if clr_entry_valid is set and clr_entry_idx equals set_fwd_stall_entry: go directly to ENDED.
REQ-022 STALLED + clr_entry_valid with clr_entry_idx equal to the stored index: go to ENDED. A non-matching index has no effect.
REQ-023 STALLED: stall_cycles increments by 1 per cycle and saturates at all-ones; it holds its value in other states.
REQ-024 ENDED: fwd_stall_ended is held until set_fwd_in_from_stalled, whatever the decode_en gaps; the payload stays stable.
REQ-025 ENDED + set_fwd_in_from_stalled: go to IDLE; the payload outputs are valid in that same cycle.
REQ-026 ENDED + set_fwd_in_from_stalled + set_fwd_stall (replay re-conflicts): capture the new payload and index, go to STALLED, restart stall_cycles at 0. REQ-021 also applies here.
REQ-027 set_fwd_stall in STALLED, or in ENDED without set_fwd_in_from_stalled: ignore it, keep state and payload, set stall_protocol_err.
REQ-028 set_fwd_in_from_stalled outside ENDED: no state change, and stall_protocol_err is set.
REQ-029 Payload registers SHALL load only on an accepted capture.

Reset
REQ-030 rst asserted SHALL immediately force: IDLE, fwd_stall=0, fwd_stall_ended=0, all payload registers 0, stored index 0, stall_cycles=0, stall_protocol_err=0.
REQ-031 Reset mid-stall SHALL drop the parked forward with no replay.

Structure
REQ-032 The state enum and STALL_CNT_BITS default SHALL be in spandex_consts.svh / spandex_types.svh; line_addr_t, mix_msg_t, cache_id_t and word_mask_t are reused from spandex_types.svh.
REQ-033 The block SHALL be a single module with no sub-modules; it sits directly upstream of the L2 input decoder and drives its fwd_stall and fwd_stall_ended inputs.

Verification
REQ-034 set_fwd_stall, entry 3, addr 0x1A2B -> fwd_stall=1 next cycle; clr entry 3 after 5 cycles -> fwd_stall_ended=1, stall_cycles=5.
REQ-035 In STALLED on entry 3, clr entry 2 -> state unchanged, fwd_stall_ended=0.
REQ-036 Same-cycle set_fwd_stall entry 1 + clr entry 1 -> ENDED next cycle, stall_cycles=0.
REQ-037 In ENDED, set_fwd_in_from_stalled + set_fwd_stall entry 4, addr 0x77 -> STALLED, payload addr 0x77, stall_cycles=0.
REQ-038 STALLED, pulse rst -> all outputs 0 at once; set_fwd_in_from_stalled afterwards -> stall_protocol_err=1.
REQ-039 Hold STALLED for 2^STALL_CNT_BITS+3 cycles -> stall_cycles saturates at all-ones.
